averager_multi: RTL and testbench

Parametrised, multi-channel successor to the simple averager. It accepts time-multiplexed samples tagged with a channel index and keeps an independent accumulator per channel. It runs in one of two modes: block averaging (one result per 2^POWER samples) or exponential moving average (one result per sample). Results are Q-format words with POWER extra fractional bits, and the block sits between the discrete ADC sample stream and downstream processing.

---
 rtl/averager_multi_pkg.sv | 25 ++
 rtl/averager_multi_if.sv | 40 ++++
 rtl/averager_multi_datapath.sv | 76 +++++++
 rtl/averager_multi.sv | 190 +++++++++++++++++++
 tb/tb_averager_multi.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/averager_multi_pkg.sv
// -----------------------------------------------------------------------------
// averager_pkg
// Shared types and sizing helpers for the multi-channel averager slice.
//   avg_mode_e : averaging mode (block average or exponential moving average)
//   qw()       : result word width, DW integer bits plus POWER fraction bits
//   ch_width() : channel index width, never narrower than CH_W_MIN
// -----------------------------------------------------------------------------
package averager_pkg;

    typedef enum logic {
        AVG_BLOCK = 1'b0,
        AVG_EMA   = 1'b1
    } avg_mode_e;

    localparam int CH_W_MIN = 1;

    function automatic int qw(input int dw, input int power);
        return dw + power;
    endfunction

    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : CH_W_MIN;
    endfunction

endpackage

// File: rtl/averager_multi_if.sv
// -----------------------------------------------------------------------------
// averager_multi_if
// Sample stream in / result stream out of the multi-channel averager.
//   din_valid, din_ch, Din        : tagged sample from the ADC side
//   q_valid, q_ch, Q, q_min, q_max: one-cycle result strobe and held results
// Modports:
//   master : sample producer / result consumer (testbench, upstream logic)
//   slave  : the averager itself
// -----------------------------------------------------------------------------
interface averager_multi_if
    import averager_pkg::*;
#(
    parameter int DW    = 8,
    parameter int POWER = 8,
    parameter int CH    = 4
);
    localparam int CH_W = ch_width(CH);
    localparam int QW   = qw(DW, POWER);

    logic            din_valid;
    logic [CH_W-1:0] din_ch;
    logic [DW-1:0]   Din;

    logic            q_valid;
    logic [CH_W-1:0] q_ch;
    logic [QW-1:0]   Q;
    logic [DW-1:0]   q_min;
    logic [DW-1:0]   q_max;

    modport master (
        output din_valid, din_ch, Din,
        input  q_valid, q_ch, Q, q_min, q_max
    );

    modport slave (
        input  din_valid, din_ch, Din,
        output q_valid, q_ch, Q, q_min, q_max
    );

endinterface

// File: rtl/averager_multi_datapath.sv
// -----------------------------------------------------------------------------
// averager_datapath
// Purely combinational update for the one channel selected this cycle.
// Ports:
//   mode         : active averaging mode
//   acc_in       : current accumulator of the selected channel
//   cnt_in       : current sample count of the selected channel (block mode)
//   primed_in    : channel has seen its first EMA sample
//   din          : incoming unsigned sample
//   acc_next     : accumulator value to store if the sample is accepted
//   cnt_next     : sample count to store if the sample is accepted
//   primed_next  : primed flag to store if the sample is accepted
//   result       : Q value to publish when result_ready is high
//   result_ready : this sample completes a result
// -----------------------------------------------------------------------------
module averager_datapath
    import averager_pkg::*;
#(
    parameter int DW    = 8,
    parameter int POWER = 8,
    localparam int QW   = qw(DW, POWER)
)
(
    input  avg_mode_e        mode,
    input  logic [QW-1:0]    acc_in,
    input  logic [POWER-1:0] cnt_in,
    input  logic             primed_in,
    input  logic [DW-1:0]    din,
    output logic [QW-1:0]    acc_next,
    output logic [POWER-1:0] cnt_next,
    output logic             primed_next,
    output logic [QW-1:0]    result,
    output logic             result_ready
);

    logic [QW-1:0] din_ext;
    logic [QW-1:0] din_shl;
    logic [QW-1:0] block_sum;
    logic [QW-1:0] ema_step;
    logic [QW-1:0] ema_acc;

    assign din_ext   = {{POWER{1'b0}}, din};
    assign din_shl   = {din, {POWER{1'b0}}};
    assign block_sum = acc_in + din_ext;
    // acc holds the average scaled by 2^POWER, so subtracting acc>>POWER and
    // adding the raw sample is the usual alpha = 2^-POWER EMA in Q format.
    assign ema_step  = acc_in - (acc_in >> POWER) + din_ext;
    // The first EMA sample seeds the filter instead of ramping up from zero.
    assign ema_acc   = primed_in ? ema_step : din_shl;

    always_comb begin
        acc_next     = acc_in;
        cnt_next     = cnt_in;
        primed_next  = primed_in;
        result       = '0;
        result_ready = 1'b0;
        if (mode == AVG_BLOCK) begin
            result = block_sum;
            // Count reaches all-ones on the 2^POWER-th sample of the block.
            if (cnt_in == {POWER{1'b1}}) begin
                acc_next     = '0;
                cnt_next     = '0;
                result_ready = 1'b1;
            end else begin
                acc_next = block_sum;
                cnt_next = cnt_in + POWER'(1);
            end
        end else begin
            acc_next     = ema_acc;
            primed_next  = 1'b1;
            result       = ema_acc;
            result_ready = 1'b1;
        end
    end

endmodule

// File: rtl/averager_multi.sv
// -----------------------------------------------------------------------------
// averager_multi
// Multi-channel averager for a time-multiplexed ADC sample stream. Keeps one
// accumulator per channel and produces either one block average per 2^POWER
// samples (AVG_BLOCK) or one exponential moving average per sample (AVG_EMA).
// Results carry POWER fractional bits: Q[QW-1:POWER] integer, Q[POWER-1:0]
// fraction.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   EN       : global enable, holds all state while low
//   clear    : synchronous clear of every channel's state
//   mode     : 0 = AVG_BLOCK, 1 = AVG_EMA (registered; a change clears state)
//   bus      : averager_multi_if.slave carrying samples in and results out
// Configuration:
//   AVG_MINMAX_EN : when defined, per-channel block min/max are tracked and
//                   published on q_min/q_max at block end; otherwise both
//                   outputs are tied to zero.
// -----------------------------------------------------------------------------
module averager_multi
    import averager_pkg::*;
#(
    parameter int DW    = 8,
    parameter int POWER = 8,
    parameter int CH    = 4
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               EN,
    input  logic               clear,
    input  logic               mode,
    averager_multi_if.slave    bus
);

    localparam int CH_W = ch_width(CH);
    localparam int QW   = qw(DW, POWER);
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CH);

    avg_mode_e       mode_in;
    avg_mode_e       mode_r;
    logic            mode_change;
    logic            ch_ok;
    logic            accept;
    logic [CH_W-1:0] sel;

    logic [QW-1:0]    acc_r    [CH];
    logic [POWER-1:0] cnt_r    [CH];
    logic             primed_r [CH];

    logic [QW-1:0]    acc_nxt;
    logic [POWER-1:0] cnt_nxt;
    logic             primed_nxt;
    logic [QW-1:0]    result;
    logic             ready;

    logic            q_valid_r;
    logic [CH_W-1:0] q_ch_r;
    logic [QW-1:0]   q_r;
    logic [DW-1:0]   q_min_r;
    logic [DW-1:0]   q_max_r;

    assign mode_in = avg_mode_e'(mode);

    // Mode is only sampled while enabled, so a disabled block cannot have its
    // channel state wiped by a mode pin that moved in the meantime.
    assign mode_change = EN && (mode_in != mode_r);
    assign ch_ok       = {1'b0, bus.din_ch} < CH_LIMIT;
    assign accept      = EN && bus.din_valid && !clear && ch_ok && !mode_change;
    // Out-of-range channels are never accepted; steering them to channel 0
    // keeps every array read in bounds.
    assign sel         = ch_ok ? bus.din_ch : '0;

    averager_datapath #(
        .DW    (DW),
        .POWER (POWER)
    ) u_datapath (
        .mode         (mode_r),
        .acc_in       (acc_r[sel]),
        .cnt_in       (cnt_r[sel]),
        .primed_in    (primed_r[sel]),
        .din          (bus.Din),
        .acc_next     (acc_nxt),
        .cnt_next     (cnt_nxt),
        .primed_next  (primed_nxt),
        .result       (result),
        .result_ready (ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r <= AVG_BLOCK;
        end else if (EN) begin
            mode_r <= mode_in;
        end
    end

    // clear is an explicit command and acts even while EN is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                acc_r[i]    <= '0;
                cnt_r[i]    <= '0;
                primed_r[i] <= 1'b0;
            end
        end else if (clear || mode_change) begin
            for (int i = 0; i < CH; i++) begin
                acc_r[i]    <= '0;
                cnt_r[i]    <= '0;
                primed_r[i] <= 1'b0;
            end
        end else if (accept) begin
            acc_r[sel]    <= acc_nxt;
            cnt_r[sel]    <= cnt_nxt;
            primed_r[sel] <= primed_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid_r <= 1'b0;
            q_ch_r    <= '0;
            q_r       <= '0;
        end else begin
            q_valid_r <= accept && ready;
            if (accept && ready) begin
                q_ch_r <= sel;
                q_r    <= result;
            end
        end
    end

`ifdef AVG_MINMAX_EN
    logic [DW-1:0] min_r [CH];
    logic [DW-1:0] max_r [CH];
    logic [DW-1:0] blk_min;
    logic [DW-1:0] blk_max;
    logic          blk_update;

    assign blk_update = accept && (mode_r == AVG_BLOCK);

    // Extremes including the current sample, so the block-end sample counts.
    always_comb begin
        blk_min = (bus.Din < min_r[sel]) ? bus.Din : min_r[sel];
        blk_max = (bus.Din > max_r[sel]) ? bus.Din : max_r[sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                min_r[i] <= '1;
                max_r[i] <= '0;
            end
        end else if (clear || mode_change) begin
            for (int i = 0; i < CH; i++) begin
                min_r[i] <= '1;
                max_r[i] <= '0;
            end
        end else if (blk_update) begin
            if (ready) begin
                min_r[sel] <= '1;
                max_r[sel] <= '0;
            end else begin
                min_r[sel] <= blk_min;
                max_r[sel] <= blk_max;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_min_r <= '0;
            q_max_r <= '0;
        end else if (blk_update && ready) begin
            q_min_r <= blk_min;
            q_max_r <= blk_max;
        end
    end
`else
    assign q_min_r = '0;
    assign q_max_r = '0;
`endif

    assign bus.q_valid = q_valid_r;
    assign bus.q_ch    = q_ch_r;
    assign bus.Q       = q_r;
    assign bus.q_min   = q_min_r;
    assign bus.q_max   = q_max_r;

endmodule

// File: tb/tb_averager_multi.sv
// -----------------------------------------------------------------------------
// tb_averager_multi
// Directed bench for averager_multi with DW=8, POWER=4, CH=3. Three channels
// leave channel index 3 representable but out of range. Expected min/max
// follow AVG_MINMAX_EN so the bench works in both builds.
// -----------------------------------------------------------------------------
module tb_averager_multi;

    localparam int DW    = 8;
    localparam int POWER = 4;
    localparam int CH    = 3;

    localparam logic [7:0] MM_VALS [16] = '{
        8'h10, 8'h0C, 8'h12, 8'h14, 8'h0E, 8'h10, 8'h11, 8'h0F,
        8'h13, 8'h0D, 8'h10, 8'h10, 8'h0E, 8'h12, 8'h10, 8'h10
    };

    logic clk = 1'b0;
    logic reset_n;
    logic EN;
    logic clear;
    logic mode;

    averager_multi_if #(.DW(DW), .POWER(POWER), .CH(CH)) bus ();

    averager_multi #(.DW(DW), .POWER(POWER), .CH(CH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .EN      (EN),
        .clear   (clear),
        .mode    (mode),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;
    logic [11:0] sq_q  [$];
    logic [1:0]  sq_ch [$];

    // Log every result strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.q_valid === 1'b1) begin
            strobes++;
            sq_q.push_back(bus.Q);
            sq_ch.push_back(bus.q_ch);
        end
    end

    function automatic logic [7:0] mmExp(input logic [7:0] v);
`ifdef AVG_MINMAX_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkStrobe(input string tag, input int idx,
                               input logic [1:0] ch, input logic [11:0] q);
        if (sq_q.size() > idx) begin
            checkOutput({tag, "_ch"}, 32'(sq_ch[idx]), 32'(ch));
            checkOutput({tag, "_Q"}, 32'(sq_q[idx]), 32'(q));
        end else begin
            checkOutput({tag, "_missing"}, sq_q.size(), idx + 1);
        end
    endtask

    task automatic clearLog();
        sq_q.delete();
        sq_ch.delete();
        strobes = 0;
    endtask

    task automatic applyStimulus(input logic en, input logic v,
                                 input logic [1:0] ch, input logic [7:0] d);
        @(posedge clk);
        #2;
        EN            = en;
        clear         = 1'b0;
        bus.din_valid = v;
        bus.din_ch    = ch;
        bus.Din       = d;
    endtask

    task automatic applyMode(input logic m, input logic v,
                             input logic [1:0] ch, input logic [7:0] d);
        @(posedge clk);
        #2;
        mode          = m;
        EN            = 1'b1;
        clear         = 1'b0;
        bus.din_valid = v;
        bus.din_ch    = ch;
        bus.Din       = d;
    endtask

    task automatic applyClear(input logic v, input logic [1:0] ch,
                              input logic [7:0] d);
        @(posedge clk);
        #2;
        EN            = 1'b1;
        clear         = 1'b1;
        bus.din_valid = v;
        bus.din_ch    = ch;
        bus.Din       = d;
    endtask

    task automatic sendBlock(input logic [1:0] ch, input logic [7:0] d, input int n);
        repeat (n) applyStimulus(1'b1, 1'b1, ch, d);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        reset_n       = 1'b0;
        EN            = 1'b1;
        clear         = 1'b0;
        mode          = 1'b0;
        bus.din_valid = 1'b0;
        bus.din_ch    = '0;
        bus.Din       = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_q_valid", bus.q_valid, 0);
        checkOutput("rst_q_ch", bus.q_ch, 0);
        checkOutput("rst_Q", bus.Q, 0);
        checkOutput("rst_q_min", bus.q_min, 0);
        checkOutput("rst_q_max", bus.q_max, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Block of 16 x 0x10 on ch0, exact strobe timing
        clearLog();
        sendBlock(2'd0, 8'h10, 16);
        @(negedge clk);
        checkOutput("blk_early_q_valid", bus.q_valid, 0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("blk_q_valid", bus.q_valid, 1);
        checkOutput("blk_Q", bus.Q, 12'h100);
        checkOutput("blk_q_ch", bus.q_ch, 0);
        checkOutput("blk_q_min", bus.q_min, mmExp(8'h10));
        checkOutput("blk_q_max", bus.q_max, mmExp(8'h10));
        @(negedge clk);
        checkOutput("blk_pulse_end", bus.q_valid, 0);
        checkOutput("blk_Q_hold", bus.Q, 12'h100);
        checkOutput("blk_strobes", strobes, 1);

        // Interleaved channels
        clearLog();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 8'h05);
            applyStimulus(1'b1, 1'b1, 2'd1, 8'hB7);
        end
        idleCycles(3);
        checkOutput("ilv_strobes", strobes, 2);
        checkStrobe("ilv_first", 0, 2'd0, 12'h050);
        checkStrobe("ilv_second", 1, 2'd1, 12'hB70);

        // EN low and out-of-range channel do not count
        clearLog();
        sendBlock(2'd0, 8'h30, 8);
        repeat (10) applyStimulus(1'b0, 1'b1, 2'd0, 8'hFF);
        repeat (3) applyStimulus(1'b1, 1'b1, 2'd3, 8'hFF);
        sendBlock(2'd0, 8'h30, 7);
        idleCycles(2);
        checkOutput("en_no_early_strobe", strobes, 0);
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h30);
        idleCycles(2);
        checkOutput("en_strobes", strobes, 1);
        checkStrobe("en_result", 0, 2'd0, 12'h300);

        // Reset mid-block discards the partial sum
        clearLog();
        sendBlock(2'd0, 8'h70, 8);
        @(posedge clk);
        #2;
        reset_n       = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        checkOutput("midrst_Q", bus.Q, 0);
        checkOutput("midrst_q_valid", bus.q_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        sendBlock(2'd0, 8'h20, 16);
        idleCycles(1);
        @(negedge clk);
        checkOutput("midrst_after_q_valid", bus.q_valid, 1);
        checkOutput("midrst_after_Q", bus.Q, 12'h200);
        idleCycles(2);
        checkOutput("midrst_strobes", strobes, 1);

        // Mode toggle mid-block discards the partial sum and drops its samples
        clearLog();
        sendBlock(2'd1, 8'h40, 5);
        applyMode(1'b1, 1'b1, 2'd1, 8'h99);
        applyMode(1'b0, 1'b1, 2'd1, 8'h99);
        sendBlock(2'd1, 8'h22, 16);
        idleCycles(3);
        checkOutput("mode_strobes", strobes, 1);
        checkStrobe("mode_result", 0, 2'd1, 12'h220);
        checkOutput("mode_q_min", bus.q_min, mmExp(8'h22));

        // EMA: seed, steady, step, then an independent channel
        clearLog();
        applyMode(1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h55);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h55);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h65);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h65);
        applyStimulus(1'b1, 1'b1, 2'd0, 8'h10);
        idleCycles(2);
        checkOutput("ema_strobes", strobes, 5);
        checkStrobe("ema_seed", 0, 2'd1, 12'h550);
        checkStrobe("ema_steady", 1, 2'd1, 12'h550);
        checkStrobe("ema_step", 2, 2'd1, 12'h560);
        checkStrobe("ema_step2", 3, 2'd1, 12'h56F);
        checkStrobe("ema_ch0_seed", 4, 2'd0, 12'h100);
        checkOutput("ema_q_min_hold", bus.q_min, mmExp(8'h22));
        checkOutput("ema_q_max_hold", bus.q_max, mmExp(8'h22));

        // clear wins over a simultaneous sample and unprimes the channel
        clearLog();
        applyClear(1'b1, 2'd1, 8'hAA);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h20);
        applyStimulus(1'b1, 1'b1, 2'd1, 8'h20);
        idleCycles(2);
        checkOutput("clr_strobes", strobes, 2);
        checkStrobe("clr_reseed", 0, 2'd1, 12'h200);
        checkStrobe("clr_steady", 1, 2'd1, 12'h200);

        // Block min/max, then a second block to show min/max restart
        clearLog();
        applyMode(1'b0, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, MM_VALS[i]);
        end
        idleCycles(2);
        checkOutput("mm_strobes", strobes, 1);
        checkStrobe("mm_sum", 0, 2'd0, 12'h100);
        checkOutput("mm_q_min", bus.q_min, mmExp(8'h0C));
        checkOutput("mm_q_max", bus.q_max, mmExp(8'h14));
        sendBlock(2'd0, 8'h30, 16);
        idleCycles(2);
        checkOutput("mm2_strobes", strobes, 2);
        checkStrobe("mm2_sum", 1, 2'd0, 12'h300);
        checkOutput("mm2_q_min", bus.q_min, mmExp(8'h30));
        checkOutput("mm2_q_max", bus.q_max, mmExp(8'h30));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
